// File: rtl/button_conditioner_if.sv
// Purpose: raw button levels in, conditioned move pulses and debounced levels out.
// Latency: none (wires only).
// Backpressure: none; pulses are fire-and-forget, one step per pulse.
interface button_conditioner_if;
    logic       btnU;
    logic       btnD;
    logic       btnL;
    logic       btnR;
    logic       btnU_pulse;
    logic       btnD_pulse;
    logic       btnL_pulse;
    logic       btnR_pulse;
    logic [3:0] btn_level;

    // Board / position-logic side: drives raw buttons, consumes pulses.
    modport master (
        output btnU, btnD, btnL, btnR,
        input  btnU_pulse, btnD_pulse, btnL_pulse, btnR_pulse, btn_level
    );

    // Conditioner side.
    modport slave (
        input  btnU, btnD, btnL, btnR,
        output btnU_pulse, btnD_pulse, btnL_pulse, btnR_pulse, btn_level
    );
endinterface

// File: rtl/button_conditioner.sv
// Purpose: synchronize, debounce, auto-repeat and arbitrate four push-buttons into one-hot move pulses.
// Latency: press pulse and level rise DEBOUNCE_CYCLES+2 edges after the first edge sampling the raw level.
// Backpressure: none; lower-priority events colliding with a higher one are dropped, never queued.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX) + 1;

    localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    // Bit order everywhere: 3 = U, 2 = D, 1 = L, 0 = R (bit 3 has highest priority).
    logic [3:0]    raw;
    logic [3:0]    meta;
    logic [3:0]    sync;
    logic [3:0]    db;
    logic [CW-1:0] cnt [4];
    logic [RW-1:0] rc  [4];
    logic [3:0]    rep_phase;   // 0: waiting for first repeat, 1: periodic repeats
    logic [3:0]    accept;
    logic [3:0]    press_ev;
    logic [3:0]    release_ev;
    logic [3:0]    rep_hit;
    logic [3:0]    rep_ev;
    logic [3:0]    cand;
    logic [3:0]    grant;
    logic [3:0]    pulse;

    assign raw = {bus.btnU, bus.btnD, bus.btnL, bus.btnR};

    // Two-flop synchronizer per button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Event decode: accepts, repeat hits and fixed-priority arbitration.
    always_comb begin
        accept  = '0;
        rep_hit = '0;
        for (int i = 0; i < 4; i++) begin
            accept[i]  = (sync[i] != db[i]) && (cnt[i] == DB_LAST);
            rep_hit[i] = rep_phase[i] ? (rc[i] == PERIOD_LAST) : (rc[i] == DELAY_LAST);
        end
        press_ev   = accept & sync;
        release_ev = accept & ~sync;
        // No repeat on the edge where the level is being released.
        rep_ev     = REPEAT_EN ? (db & ~release_ev & rep_hit) : 4'b0000;
        cand       = press_ev | rep_ev;
        grant[3]   = cand[3];
        grant[2]   = cand[2] & ~cand[3];
        grant[1]   = cand[1] & ~(|cand[3:2]);
        grant[0]   = cand[0] & ~(|cand[3:1]);
    end

    // Debounce: a differing level must hold DEBOUNCE_CYCLES cycles; any bounce restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    db[i]  <= sync[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Auto-repeat timers; they keep running even when the resulting event loses arbitration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_phase <= '0;
            for (int i = 0; i < 4; i++) rc[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!REPEAT_EN || !db[i] || press_ev[i]) begin
                    rc[i]        <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (rep_hit[i]) begin
                    rc[i]        <= '0;
                    rep_phase[i] <= 1'b1;
                end else begin
                    rc[i]        <= rc[i] + RW'(1);
                end
            end
        end
    end

    // Registered one-hot move pulses, aligned with the debounced level update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse <= '0;
        end else begin
            pulse <= grant;
        end
    end

    assign bus.btnU_pulse = pulse[3];
    assign bus.btnD_pulse = pulse[2];
    assign bus.btnL_pulse = pulse[1];
    assign bus.btnR_pulse = pulse[0];
    assign bus.btn_level  = db;

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage between the four raw push-buttons and the position-update logic. Each raw button is synchronized, debounced and converted to single-cycle move pulses, with optional auto-repeat while a button is held. Simultaneous presses are arbitrated so that at most one move pulse is issued per clock, in priority U > D > L > R. The downstream position register consumes the pulse outputs directly, one step per pulse.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive synchronized cycles a new level must hold before it is accepted (≥1).
- REPEAT_EN, 0: 1 enables auto-repeat while a button is held.
- REPEAT_DELAY, 25000000: cycles from press pulse to first repeat pulse (≥1).
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat pulses (≥1).
- clk  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- btnU, btnD, btnL, btnR  in  1 each  raw, asynchronous, bouncing button levels.
- btnU_pulse, btnD_pulse, btnL_pulse, btnR_pulse  out  1 each  registered one-cycle move pulses; at most one high per cycle.
- btn_level  out  4  registered debounced levels {U,D,L,R}, bit 3 = U.

## Operation
- Synchronizer: two flops per button, reset to 0; debounce logic sees only the second flop (sync).
- Debounce, per button: accepted level db (reset 0), counter cnt (width $clog2(DEBOUNCE_CYCLES)+1, reset 0).
  - sync == db: cnt <= 0.
  - sync != db and cnt == DEBOUNCE_CYCLES-1: db <= sync, cnt <= 0 (accept).
  - otherwise cnt <= cnt+1. Any bounce back to db restarts the count.
- Press event: accept with sync = 1. Release accept (sync = 0) produces no pulse.
- Auto-repeat, per button: counter rc, cleared on press event and whenever db = 0. While db = 1 and REPEAT_EN = 1, repeat event when rc reaches REPEAT_DELAY-1 (first) and every REPEAT_PERIOD cycles afterwards. No counter wraps; rc reloads on each repeat. REPEAT_EN = 0: rc is held at 0 and never fires.
- Arbitration: the candidate vector is press|repeat events per button. U passes unconditionally; D is masked by U; L by U|D; R by U|D|L. Masked events are dropped, not queued, and do not reset that button's repeat schedule.
- btn_level follows db directly and is never masked.

## Timing
- Reset: all outputs, db, cnt, rc and synchronizer flops are 0 immediately on reset assertion, with no clock required. Held at 0 while reset is high.
- Press latency: if edge 1 is the first edge sampling a raw 1, the pulse and the btn_level bit go high after edge DEBOUNCE_CYCLES+2. The pulse is high for exactly one cycle.
- Release latency: btn_level bit falls after edge DEBOUNCE_CYCLES+2, counted from the first edge sampling raw 0.
- Repeat: press pulse at edge P gives repeats at P+REPEAT_DELAY, then +REPEAT_PERIOD each, while db = 1. Repeating stops on the edge db falls.
- Glitch rejection: a level differing for fewer than DEBOUNCE_CYCLES synchronized cycles is never accepted.
- Reset mid-hold: after release, a still-held button is re-debounced from db = 0. It emits a fresh press pulse DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
- Simultaneous events in one cycle: the highest-priority button pulses and the others are lost for that cycle.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press, REPEAT_EN=0: btnU high from edge 1 for 20 cycles, then low. Expect btnU_pulse high only after edge 6, and btn_level[3] high from edge 6 until 6 edges after release. No pulse on release.
- Bounce: btnL alternates 1/0 each cycle for 6 cycles, then stays 1 from edge k. Expect exactly one btnL_pulse, after edge k+5.
- Glitch: btnR high for 3 cycles, then low. Expect no pulse and btn_level[0] stays 0.
- Auto-repeat, REPEAT_EN=1: btnD high from edge 1, first raw 0 sampled at edge 31. Expect btnD_pulse after edges 6, 16, 19, 22, 25, 28, 31, 34 and none after, with btn_level[2] falling after edge 36.
- Simultaneous: btnU and btnR rise in the same cycle. Expect btnU_pulse after edge 6 and btnR_pulse never; btn_level = 4'b1001 from edge 6.
- Reset mid-hold: btnL held, reset asserted between edges with no clock. Expect outputs 0 immediately. After reset deasserts with btnL still high, expect btnL_pulse 6 edges after the first post-reset edge.
